mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: request FIFO entries; power of two, >= 2.
REQ-002 Parameter MEM_AW, default 8: implemented memory index bits (256 words).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 req_valid  input  1  upstream request present.
REQ-006 req_ready  output  1  FIFO can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  24  word address.
REQ-009 req_wdata  input  24  store data.
REQ-010 addr  output  24  memory address, to the memory's addr.
REQ-011 din  output  24  memory write data, to the memory's din.
REQ-012 we  output  1  memory write enable, to the memory's we.
REQ-013 dout  input  24  memory combinational read data, mem[addr].
REQ-014 rsp_valid  output  1  response present.
REQ-015 rsp_ready  input  1  consumer takes response.
REQ-016 rsp_rdata  output  24  load data; 0 for stores and errors.
REQ-017 rsp_err  output  1  request address out of range.
REQ-018 pending  output  clog2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-019 Request FIFO: push when req_valid && req_ready; req_ready = (pending != FIFO_DEPTH), with no push-through-when-full even if a pop occurs that cycle.
REQ-020 Push and pop in the same cycle leave pending unchanged; strict in-order service; pointers wrap modulo FIFO_DEPTH.
REQ-021 FSM states IDLE, ISSUE, RESP; one request in flight at a time.
REQ-022 IDLE: if pending > 0, pop head into command register, go to ISSUE; else stay.
REQ-023 addr and din driven from command register at all times; we asserted only in ISSUE.
REQ-024 ISSUE, one cycle: range error when cmd_addr[23:MEM_AW] != 0.
REQ-025 ISSUE store, in range: we = 1 for exactly that cycle; rsp_rdata <= 0, rsp_err <= 0.
REQ-026 ISSUE load, in range: we = 0; rsp_rdata <= dout, rsp_err <= 0.
REQ-027 ISSUE, range error: we = 0 (no memory write); rsp_rdata <= 0, rsp_err <= 1.
REQ-028 ISSUE always goes to RESP next cycle.
REQ-029 RESP: rsp_valid = 1; rsp_rdata and rsp_err held stable until rsp_ready; on rsp_valid && rsp_ready go to IDLE.
REQ-030 Latency, empty FIFO, rsp_ready held 1: request accepted at edge E; ISSUE cycle follows edge E+1; rsp_valid first high in the cycle after edge E+2.
REQ-031 Throughput: one request per 3 cycles maximum.
REQ-032 FIFO continues accepting while the FSM is in ISSUE or RESP.
REQ-033 Load after store to same address returns the stored value, since service is strictly sequential.

Reset
REQ-034 rst_n low, asynchronous: FSM = IDLE; FIFO pointers and pending = 0.
REQ-035 rst_n low, asynchronous: command register 0 (addr = 0, din = 0); we = 0.
REQ-036 rst_n low, asynchronous: rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-037 req_ready = 0 while rst_n is low; 1 from the first cycle after deassertion.
REQ-038 Reset mid-operation discards the in-flight request and all queued requests; no we pulse occurs during or after reset until a new request is accepted.

Verification
REQ-039 Store 0x00A5A5 to addr 0x00000D, then load addr 0x00000D -> one we pulse with addr = 0x0D and din = 0x00A5A5; two responses, second rsp_rdata = 0x00A5A5, rsp_err = 0.
REQ-040 Load addr 0x000100 -> we never asserted; rsp_err = 1, rsp_rdata = 0.
REQ-041 Burst 6 requests with rsp_ready = 0 -> req_ready falls at pending = 4; in-flight response held stable; after release, 6 responses in order.
REQ-042 Push and pop coincide at pending = 2 -> pending stays 2.
REQ-043 rst_n pulsed low in ISSUE of a store with 3 queued -> we = 0, pending = 0, rsp_valid = 0 immediately; no later response.
REQ-044 Single load with rsp_ready = 1 -> rsp_valid rises exactly 3 edges after acceptance.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Queues load/store requests in a small FIFO and serves them one at a time
// against a single-port memory with combinational read data. Each request
// takes one ISSUE cycle (memory write or read capture) and then a RESP phase
// that holds the response until the consumer takes it.
//
// Ports
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : upstream request present
//   req_ready  : FIFO can accept a request this cycle
//   req_we     : 1 = store, 0 = load
//   req_addr   : 24-bit word address
//   req_wdata  : 24-bit store data
//   addr       : memory address (from command register)
//   din        : memory write data (from command register)
//   we         : memory write enable (ISSUE cycle of an in-range store only)
//   dout       : memory combinational read data, mem[addr]
//   rsp_valid  : response present
//   rsp_ready  : consumer takes response
//   rsp_rdata  : load data, 0 for stores and errors
//   rsp_err    : request address out of implemented range
//   pending    : FIFO occupancy
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int MEM_AW     = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_we,
   input  logic [23:0]                   req_addr,
   input  logic [23:0]                   req_wdata,
   output logic [23:0]                   addr,
   output logic [23:0]                   din,
   output logic                          we,
   input  logic [23:0]                   dout,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [23:0]                   rsp_rdata,
   output logic                          rsp_err,
   output logic [$clog2(FIFO_DEPTH):0]   pending
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t          r_state;

   logic [PW-1:0]   r_wrPtr;
   logic [PW-1:0]   r_rdPtr;
   logic [CW-1:0]   r_count;
   logic            r_fifoWe   [FIFO_DEPTH];
   logic [23:0]     r_fifoAddr [FIFO_DEPTH];
   logic [23:0]     r_fifoData [FIFO_DEPTH];

   logic            r_cmdWe;
   logic [23:0]     r_cmdAddr;
   logic [23:0]     r_cmdData;

   logic            r_rspValid;
   logic [23:0]     r_rspRdata;
   logic            r_rspErr;

   logic            w_full;
   logic            w_push;
   logic            w_pop;
   logic            w_inRange;

   // Full is judged on the current occupancy only, so a pop in the same cycle
   // never opens a slot for a push. Ready is also forced low while in reset.
   assign w_full    = (r_count == FULL_COUNT);
   assign req_ready = rst_n && !w_full;
   assign w_push    = req_valid && req_ready;
   assign w_pop     = (r_state == IDLE) && (r_count != '0);

   // Any address bit above the implemented index makes the request an error.
   assign w_inRange = ((r_cmdAddr >> MEM_AW) == 24'd0);

   assign addr      = r_cmdAddr;
   assign din       = r_cmdData;
   assign we        = (r_state == ISSUE) && r_cmdWe && w_inRange;
   assign rsp_valid = r_rspValid;
   assign rsp_rdata = r_rspRdata;
   assign rsp_err   = r_rspErr;
   assign pending   = r_count;

   // FIFO storage needs no reset; only the pointers and count define content.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifoWe[r_wrPtr]   <= req_we;
         r_fifoAddr[r_wrPtr] <= req_addr;
         r_fifoData[r_wrPtr] <= req_wdata;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally because the
   // depth is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // Service FSM: one request in flight; response fields are captured in
   // ISSUE and then held until the consumer accepts them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cmdWe    <= 1'b0;
         r_cmdAddr  <= '0;
         r_cmdData  <= '0;
         r_rspValid <= 1'b0;
         r_rspRdata <= '0;
         r_rspErr   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_cmdWe   <= r_fifoWe[r_rdPtr];
                  r_cmdAddr <= r_fifoAddr[r_rdPtr];
                  r_cmdData <= r_fifoData[r_rdPtr];
                  r_state   <= ISSUE;
               end
            end
            ISSUE: begin
               r_rspValid <= 1'b1;
               r_state    <= RESP;
               if (!w_inRange) begin
                  r_rspRdata <= '0;
                  r_rspErr   <= 1'b1;
               end else if (r_cmdWe) begin
                  r_rspRdata <= '0;
                  r_rspErr   <= 1'b0;
               end else begin
                  r_rspRdata <= dout;
                  r_rspErr   <= 1'b0;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rspValid <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_rspValid <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

endmodule
